// File: rtl/avr_prefetch.sv
// Instruction prefetch queue between synchronous program memory and the AVR core.
// Tags each fetched word with its address and presents 16/32-bit instructions whole.
module avr_prefetch #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] p_addr,
    output logic        p_rd,
    input  logic [15:0] p_data,
    output logic [15:0] instr,
    output logic [15:0] instr_ext,
    output logic        instr_is32,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [15:0]   fifo_word [DEPTH];
    logic [15:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] nxt_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] pop_n;
    logic          inflight;
    logic [15:0]   fetch_pc;
    logic [15:0]   issue_pc_p1;
    logic [15:0]   head_word;
    logic          head_is32;
    logic          head_ok;
    logic          push;
    logic          pop;

    // JMP/CALL and LDS/STS carry a second program word
    function automatic logic is32_op(input logic [15:0] w);
        return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
    endfunction

    // Stage 0: issue; in-flight reads count against FIFO space so capture never overflows
    always_comb begin
        p_addr = 16'h0000;
        p_rd   = 1'b0;
        if (RST_N) begin
            p_addr = redirect ? redirect_pc : fetch_pc;
            p_rd   = redirect | (({1'b0, count} + {{CW{1'b0}}, inflight}) < DEPTH_C);
        end
    end

    // Stage 1: capture and head presentation
    assign nxt_ptr   = rd_ptr + PW'(1);
    assign head_word = fifo_word[rd_ptr];
    assign head_is32 = is32_op(head_word);
    assign head_ok   = RST_N & (count != '0) & (!head_is32 | (count >= CW'(2)));
    assign push      = RST_N & inflight & !redirect;
    assign pop       = instr_valid & instr_ready;

    always_comb begin
        instr       = 16'h0000;
        instr_ext   = 16'h0000;
        instr_is32  = 1'b0;
        instr_pc    = 16'h0000;
        instr_valid = 1'b0;
        pop_n       = '0;
        if (head_ok) begin
            instr       = head_word;
            instr_ext   = head_is32 ? fifo_word[nxt_ptr] : 16'h0000;
            instr_is32  = head_is32;
            instr_pc    = fifo_pc[rd_ptr];
            instr_valid = 1'b1;
        end
        if (pop)
            pop_n = instr_is32 ? CW'(2) : CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fetch_pc <= 16'h0000;
            count    <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= p_rd;
            if (p_rd)
                fetch_pc <= p_addr + 16'd1;
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count + CW'(push) - pop_n;
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(pop_n);
            end
        end
    end

    always_ff @(posedge CLK) begin
        issue_pc_p1 <= p_addr;
        if (push) begin
            fifo_word[wr_ptr] <= p_data;
            fifo_pc[wr_ptr]   <= issue_pc_p1;
        end
    end

endmodule

// File: doc/avr_prefetch.md
# avr_prefetch

Instruction prefetch queue between synchronous program memory and the AVR decode/execute core. Reads 16-bit program words ahead of the core into a small FIFO and tags each with its word address. Assembles 32-bit instructions (JMP, CALL, LDS, STS) into one decode unit. Presents them over a valid/ready handshake. Flushes and restarts on a redirect from the core (branch, jump, call, return, reset vector).

## Interface
- DEPTH, 4, FIFO depth in 16-bit words; power of two, ≥2; full throughput requires ≥3
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  synchronous, active-low reset
- redirect  in  1  core requests fetch restart at redirect_pc
- redirect_pc  in  16  new word address
- p_addr  out  16  program memory word address
- p_rd  out  1  read strobe; p_data valid exactly one cycle later
- p_data  in  16  program memory read data
- instr  out  16  first word of head instruction
- instr_ext  out  16  second word when instr_is32, else 0
- instr_is32  out  1  head instruction is two words
- instr_pc  out  16  word address of instr
- instr_valid  out  1  head instruction complete and presentable
- instr_ready  in  1  core accepts head this cycle

## Operation
- State: fetch_pc (16b), FIFO of DEPTH entries {word, pc}, count (log2(DEPTH)+1 bits), inflight flag (p_rd issued last cycle).
- Reset (RST_N=0 at edge): fetch_pc=0, count=0, inflight=0, FIFO pointers 0. While RST_N=0: p_rd=0, instr_valid=0, instr/instr_ext/instr_pc/instr_is32=0, p_addr=0.
- Issue: p_addr = redirect ? redirect_pc : fetch_pc. p_rd = RST_N & (redirect | (count + inflight < DEPTH)). On issue, fetch_pc <= p_addr + 1 (mod 2^16; 0xFFFF wraps to 0x0000).
- Capture: when inflight=1 and no redirect this cycle, p_data is pushed with pc = address issued last cycle. Capture space is guaranteed by the issue rule.
- 32-bit detect on head word w: (w & 16'hFE0C)==16'h940C (JMP/CALL), or (w & 16'hFC0F)==16'h9000 (LDS/STS).
- instr_valid = count≥1 & !is32(head), or count≥2 & is32(head). Outputs are driven from FIFO head/head+1 combinationally. All outputs are 0 when instr_valid=0.
- Pop: instr_valid & instr_ready removes 1 word, or 2 when instr_is32. Push and pop in the same cycle are both applied; count changes by push−pop.
- Redirect: FIFO cleared (count=0). Any response arriving in the redirect cycle is discarded. Read of redirect_pc is issued the same cycle. A handshake in the redirect cycle counts as accepted; its effect is subsumed by the clear.
- Redirect with RST_N=0: reset wins.
- No partial 32-bit instruction is ever presented. A lone is32 head waits with instr_valid=0 until its second word arrives.

## Timing
- Cycle 0 = first cycle with RST_N=1: p_rd=1, p_addr=0. Word 0 is captured at the end of cycle 1. instr_valid=1 in cycle 2 (16-bit op) or cycle 3 (32-bit op).
- Steady state, DEPTH≥3, ready held high: one 16-bit instruction per cycle; p_addr increments by 1 per cycle.
- Redirect in cycle r: p_addr=redirect_pc in cycle r. First new instr_valid no earlier than r+2. instr_valid=0 in r+1.
- Backpressure: p_rd deasserts once count+inflight = DEPTH. It re-asserts the cycle after a pop reduces count. No word is lost or duplicated.
- No combinational path from instr_ready to p_rd/p_addr. redirect→p_addr/p_rd is combinational.

## Test plan
- Reset release, memory holding 0x0000,0x0001,0x0002… at addresses 0,1,2… with ready=1 -> p_addr 0,1,2… per cycle. instr 0x0000 at pc 0 in cycle 2, then one per cycle with instr_pc matching. instr_is32=0.
- Memory[4]=0x940C (JMP), memory[5]=0x1234 -> single handshake with instr=0x940C, instr_ext=0x1234, instr_is32=1, instr_pc=4. Next instr_pc=6. Repeat with 0x9100/0x0060 (LDS).
- DEPTH=4, ready=0 from reset -> exactly 4 reads issued (addresses 0–3), then p_rd=0 indefinitely. After ready pulses once, exactly one new read at address 4.
- Redirect to 0x0100 while FIFO holds 3 words and a read is in flight -> in-flight data dropped. Next presented instr_pc=0x0100, and no stale pc appears.
- Redirect to 0xFFFF, memory[0xFFFF]=0x940C, memory[0]=0xABCD -> instr_pc=0xFFFF, instr_ext=0xABCD, fetch wraps to 0x0000.
- RST_N=0 for one cycle mid-stream with valid data in FIFO -> instr_valid=0 and p_rd=0 that cycle. Restart fetches from address 0, and no pre-reset word is presented.
